// File: rtl/ccr_unit.sv
//============================================================================
// Module      : ccr_unit
// Description : Condition-code register beside the EX-stage ALU. Captures the
//               C/N/Z flags, resolves and consumes branch conditions, and
//               saves/restores the flags on a small interrupt stack.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module ccr_unit #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_valid,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic [2:0] flag_mask,
    input  logic       set_c,
    input  logic       clr_c,
    input  logic       br_valid,
    input  logic [1:0] br_cond,
    input  logic       int_save,
    input  logic       rti_restore,
    output logic [2:0] flags,
    output logic       br_taken,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);

    localparam int              SP_W      = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0] C_SP_ZERO = '0;
    localparam logic [SP_W-1:0] C_SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] C_SP_FULL = SP_W'(DEPTH);

    localparam logic [1:0] C_COND_JZ  = 2'b00;
    localparam logic [1:0] C_COND_JN  = 2'b01;
    localparam logic [1:0] C_COND_JC  = 2'b10;
    localparam logic [1:0] C_COND_JMP = 2'b11;

    localparam int C_BIT_Z = 0;
    localparam int C_BIT_N = 1;
    localparam int C_BIT_C = 2;

    // Flag vector layout is {C,N,Z}, matching flag_mask bit positions.
    logic [2:0]      flags_q, flags_d;
    logic [2:0]      stack_q [DEPTH];
    logic [2:0]      stack_d [DEPTH];
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;

    logic       w_cond_hit;
    logic       w_br_taken;
    logic [2:0] w_consume;
    logic       w_push_req;
    logic       w_pop_req;
    logic       w_collide;
    logic       w_push_ok;
    logic       w_pop_ok;
    logic       w_full;
    logic       w_empty;
    logic [2:0] w_stack_top;

    // Branch resolution looks only at registered flags; same-cycle updates are
    // a hazard handled upstream by stalling.
    always_comb begin
        w_cond_hit = 1'b0;
        w_consume  = 3'b000;
        case (br_cond)
            C_COND_JZ:  w_cond_hit = flags_q[C_BIT_Z];
            C_COND_JN:  w_cond_hit = flags_q[C_BIT_N];
            C_COND_JC:  w_cond_hit = flags_q[C_BIT_C];
            C_COND_JMP: w_cond_hit = 1'b1;
            default:    w_cond_hit = 1'b0;
        endcase
        w_br_taken = br_valid & w_cond_hit;
        if (w_br_taken) begin
            case (br_cond)
                C_COND_JZ: w_consume[C_BIT_Z] = 1'b1;
                C_COND_JN: w_consume[C_BIT_N] = 1'b1;
                C_COND_JC: w_consume[C_BIT_C] = 1'b1;
                default:   w_consume          = 3'b000;
            endcase
        end
    end

    always_comb begin
        w_full     = (sp_q == C_SP_FULL);
        w_empty    = (sp_q == C_SP_ZERO);
        w_push_req = int_save & ~rti_restore;
        w_pop_req  = rti_restore & ~int_save;
        w_collide  = int_save & rti_restore;
        w_push_ok  = w_push_req & ~w_full;
        w_pop_ok   = w_pop_req & ~w_empty;
    end

    always_comb begin
        w_stack_top = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                w_stack_top = stack_q[i];
            end
        end
    end

    always_comb begin
        flags_d = flags_q;

        if (alu_valid && flag_mask[C_BIT_Z]) begin
            flags_d[C_BIT_Z] = alu_zero;
        end else if (w_consume[C_BIT_Z]) begin
            flags_d[C_BIT_Z] = 1'b0;
        end

        if (alu_valid && flag_mask[C_BIT_N]) begin
            flags_d[C_BIT_N] = alu_neg;
        end else if (w_consume[C_BIT_N]) begin
            flags_d[C_BIT_N] = 1'b0;
        end

        if (alu_valid && flag_mask[C_BIT_C]) begin
            flags_d[C_BIT_C] = alu_carry;
        end else if (set_c) begin
            flags_d[C_BIT_C] = 1'b1;
        end else if (clr_c) begin
            flags_d[C_BIT_C] = 1'b0;
        end else if (w_consume[C_BIT_C]) begin
            flags_d[C_BIT_C] = 1'b0;
        end

        if (w_pop_ok) begin
            flags_d = w_stack_top;
        end
    end

    // Push stores the pre-update flags so the handler's own ALU op in the
    // same cycle does not corrupt the saved context.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = stack_q[i];
            if (w_push_ok && (sp_q == SP_W'(i))) begin
                stack_d[i] = flags_q;
            end
        end

        sp_d = sp_q;
        if (w_push_ok) begin
            sp_d = sp_q + C_SP_ONE;
        end else if (w_pop_ok) begin
            sp_d = sp_q - C_SP_ONE;
        end

        err_d = err_q | w_collide | (w_push_req & w_full) | (w_pop_req & w_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
            sp_q    <= C_SP_ZERO;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= 3'b000;
            end
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign flags       = flags_q;
    assign br_taken    = w_br_taken;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_err   = err_q;

endmodule

`default_nettype wire
